spi_frame_serializer: RTL and testbench
=======================================

// Module: spi_frame_serializer
// PURPOSE
//  SPI controller-side serializer: the transmitting end of the 16-bit register-write frame our SPI
//  deserializer receives. Takes a parallel {read_write, addr, data} request over a valid/ready
//  handshake and drives n_cs/sclk/copi in SPI mode 0, MSB first. Used in test harnesses and
//  chip-to-chip configuration links that program the spi_peripheral/PWM register map.
// PARAMETERS
//  CLK_DIV  4  clk cycles per sclk half-period; legal >= 2 (>= 4 when the receiver shares clk)
//  CS_GAP   2  min clk cycles n_cs held high after a frame before the next may be accepted; >= 1
// PORTS
//  clk         in   1  system clock; all logic on rising edge
//  rst         in   1  reset, asynchronous, active-high
//  in_valid    in   1  request present
//  in_ready    out  1  block idle, accepts request this cycle
//  read_write  in   1  frame bit 15
//  addr        in   7  frame bits 14:8
//  data        in   8  frame bits 7:0
//  sclk        out  1  SPI clock, idle low
//  copi        out  1  controller-out data
//  n_cs        out  1  chip select, active low
//  busy        out  1  high from acceptance until return to IDLE
//  done        out  1  one-cycle pulse at frame completion
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, n_cs=1, sclk=0, copi=0, busy=0, done=0, counters=0.
//  All outputs registered; in_ready = (state==IDLE) && !rst.
//  Accept: in_valid && in_ready at edge N latches frame={read_write,addr,data}; later input
//   changes are ignored until the next acceptance. in_valid while not ready is ignored (no queue).
//  States: IDLE -> LOW -> HIGH -> LOW ... -> HOLD -> GAP -> IDLE.
//   IDLE: n_cs=1, sclk=0, copi=0, busy=0. On accept -> LOW, bit_cnt=0.
//   LOW: from cycle N+1: n_cs=0, sclk=0, copi=frame[15-bit_cnt]; CLK_DIV cycles, then HIGH.
//   HIGH: sclk=1, copi stable (receiver samples on rising sclk); CLK_DIV cycles. Then if
//    bit_cnt==15 -> HOLD, else bit_cnt+1 -> LOW (copi updates with the falling sclk edge).
//   HOLD: sclk=0, n_cs=0, copi=0; CLK_DIV cycles -> GAP.
//   GAP: n_cs=1, sclk=0; done=1 in first GAP cycle only; CS_GAP cycles -> IDLE.
//  Timing: n_cs low exactly 33*CLK_DIV cycles; exactly 16 sclk rising edges per frame;
//   acceptance-to-done = 33*CLK_DIV+1 cycles; accept-to-next-accept min 33*CLK_DIV+CS_GAP+1.
//  Back-to-back: in_valid held high -> next frame accepted on first IDLE cycle; n_cs high
//   for CS_GAP+1 cycles between frames.
//  Counters: div_cnt width $clog2(CLK_DIV)+1, bit_cnt 4 bits, gap_cnt $clog2(CS_GAP)+1;
//   no wrap-around possible in any legal state.
//  Reset mid-frame: immediate abort, n_cs rises asynchronously, no done pulse, frame discarded.
//  busy = (state != IDLE), includes GAP.
// TESTING
//  1 Write rw=1 addr=0x00 data=0xFF, CLK_DIV=4: copi at 16 sclk rises = 0x80FF; n_cs low 132 cycles.
//  2 Loopback to our deserializer+spi_peripheral: write addr=0x04 data=0x80 -> pwm_duty_cycle=0x80.
//  3 in_valid held, two frames 0xA5/0x5A: n_cs high exactly 3 cycles between; one done per frame.
//  4 Change addr/data while busy and pulse in_valid: transmitted frame unchanged, no 2nd frame.
//  5 Assert rst after 7th sclk rise: n_cs=1, sclk=0, copi=0 same cycle; no done; in_ready after release.
//  6 CLK_DIV=2, CS_GAP=1: sclk period 4 cycles, frame bits 0x0155 correct, done at accept+67.

Source files
------------

// File: rtl/spi_frame_serializer.sv
// spi_frame_serializer: mode-0 SPI controller that shifts out one 16-bit {rw,addr,data} frame per handshake
module spi_frame_serializer #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       read_write,
  input  logic [6:0] addr,
  input  logic [7:0] data,
  output logic       sclk,
  output logic       copi,
  output logic       n_cs,
  output logic       busy,
  output logic       done
);
  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam int GW = $clog2(CS_GAP) + 1;
  typedef enum logic [2:0] {IDLE, LOW, HIGH, HOLD, GAP} state_t;
  state_t state;
  logic [15:0] sh;
  logic [DW-1:0] div_cnt;
  logic [3:0] bit_cnt;
  logic [GW-1:0] gap_cnt;
  logic div_end;
  assign div_end = div_cnt == DW'(CLK_DIV - 1);
  assign in_ready = state == IDLE && !rst;
  // sequencer: each sclk half-period lasts CLK_DIV cycles; copi changes only as sclk falls
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      sh <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      sclk <= 1'b0;
      copi <= 1'b0;
      n_cs <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          state <= LOW;
          sh <= {read_write, addr, data};
          copi <= read_write;
          n_cs <= 1'b0;
          busy <= 1'b1;
          bit_cnt <= '0;
          div_cnt <= '0;
        end
        LOW: if (div_end) begin
          state <= HIGH;
          sclk <= 1'b1;
          div_cnt <= '0;
        end else div_cnt <= div_cnt + 1'b1;
        HIGH: if (div_end) begin
          sclk <= 1'b0;
          div_cnt <= '0;
          state <= bit_cnt == 4'd15 ? HOLD : LOW;
          copi <= bit_cnt == 4'd15 ? 1'b0 : sh[14];
          sh <= {sh[14:0], 1'b0};
          bit_cnt <= bit_cnt == 4'd15 ? bit_cnt : bit_cnt + 1'b1;
        end else div_cnt <= div_cnt + 1'b1;
        HOLD: if (div_end) begin
          state <= GAP;
          n_cs <= 1'b1;
          done <= 1'b1;
          div_cnt <= '0;
          gap_cnt <= '0;
        end else div_cnt <= div_cnt + 1'b1;
        GAP: if (gap_cnt == GW'(CS_GAP - 1)) begin
          state <= IDLE;
          busy <= 1'b0;
        end else gap_cnt <= gap_cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_frame_serializer.sv
// tb_spi_frame_serializer: directed checks of frame bits, timing, handshake and reset abort
module tb_spi_frame_serializer;
  logic clk = 0, rst = 1, in_valid = 0, in_valid_b = 0, read_write = 0;
  logic [6:0] addr = '0;
  logic [7:0] data = '0;
  logic in_ready, sclk, copi, n_cs, busy, done;
  logic in_ready_b, sclk_b, copi_b, n_cs_b, busy_b, done_b;
  int tests = 0, fails = 0, cyc = 0;
  logic clr = 0;
  logic sclk_q = 0, sclk_bq = 0;
  logic [15:0] rx = '0, rx_b = '0;
  logic [15:0] flog [4];
  int rises = 0, cs_low = 0, dones = 0, accs = 0, acc_cyc = 0, done_cyc = 0, hi_run = 0, last_hi = 0;
  int rises_b = 0, cs_low_b = 0, dones_b = 0, acc_cyc_b = 0, done_cyc_b = 0, rise_cyc_b = 0, period_b = 0;

  spi_frame_serializer dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .read_write(read_write), .addr(addr), .data(data), .sclk(sclk), .copi(copi), .n_cs(n_cs),
    .busy(busy), .done(done));
  spi_frame_serializer #(.CLK_DIV(2), .CS_GAP(1)) dut_b (.clk(clk), .rst(rst), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .read_write(read_write), .addr(addr), .data(data), .sclk(sclk_b),
    .copi(copi_b), .n_cs(n_cs_b), .busy(busy_b), .done(done_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // observer for the default-parameter instance, sampled mid-cycle
  always @(negedge clk)
    if (clr) begin
      rises <= 0; cs_low <= 0; dones <= 0; accs <= 0; hi_run <= 0; last_hi <= 0; rx <= '0;
    end else begin
      sclk_q <= sclk;
      if (sclk && !sclk_q) begin rx <= {rx[14:0], copi}; rises <= rises + 1; end
      if (!n_cs) cs_low <= cs_low + 1;
      if (n_cs) hi_run <= hi_run + 1;
      else if (hi_run != 0) begin last_hi <= hi_run; hi_run <= 0; end
      if (in_valid && in_ready) begin accs <= accs + 1; acc_cyc <= cyc; end
      if (done) begin flog[dones[1:0]] <= rx; dones <= dones + 1; done_cyc <= cyc; end
    end

  // observer for the CLK_DIV=2 / CS_GAP=1 instance
  always @(negedge clk)
    if (clr) begin
      rises_b <= 0; cs_low_b <= 0; dones_b <= 0; rise_cyc_b <= 0; period_b <= 0; rx_b <= '0;
    end else begin
      sclk_bq <= sclk_b;
      if (sclk_b && !sclk_bq) begin
        rx_b <= {rx_b[14:0], copi_b};
        rises_b <= rises_b + 1;
        if (rise_cyc_b != 0) period_b <= cyc - rise_cyc_b;
        rise_cyc_b <= cyc;
      end
      if (!n_cs_b) cs_low_b <= cs_low_b + 1;
      if (in_valid_b && in_ready_b) acc_cyc_b <= cyc;
      if (done_b) begin dones_b <= dones_b + 1; done_cyc_b <= cyc; end
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    @(negedge clk) clr = 1;
    @(negedge clk) clr = 0;
  endtask

  task automatic send(input bit b, input logic rw, input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    read_write = rw; addr = a; data = d;
    if (b) in_valid_b = 1; else in_valid = 1;
    @(negedge clk);
    in_valid = 0; in_valid_b = 0;
  endtask

  task automatic wait_done(input bit b, input int n);
    for (int i = 0; i < 3000 && (b ? dones_b : dones) < n; i++) @(negedge clk);
    if ((b ? dones_b : dones) < n) chk("done_timeout", b ? dones_b : dones, n);
  endtask

  initial begin
    #12;
    chk("rst_ncs", n_cs, 1); chk("rst_sclk", sclk, 0); chk("rst_copi", copi, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_ready", in_ready, 0);
    @(negedge clk) rst = 0;
    #1 chk("ready_after_rst", in_ready, 1);
    // frame 0x80FF at CLK_DIV=4
    clear();
    send(0, 1, 7'h00, 8'hFF);
    wait_done(0, 1);
    repeat (4) @(negedge clk);
    chk("t1_bits", rx, 16'h80FF); chk("t1_rises", rises, 16); chk("t1_cs_low", cs_low, 132);
    chk("t1_latency", done_cyc - acc_cyc, 133); chk("t1_one_done", dones, 1); chk("t1_ready", in_ready, 1);
    // register write addr 0x04 data 0x80
    clear();
    send(0, 1, 7'h04, 8'h80);
    wait_done(0, 1);
    chk("t2_bits", rx, 16'h8480);
    // back-to-back with in_valid held
    clear();
    @(negedge clk) read_write = 1; addr = 7'h12; data = 8'hA5; in_valid = 1;
    @(negedge clk) data = 8'h5A;
    for (int i = 0; i < 3000 && !in_ready; i++) @(negedge clk);
    @(posedge clk) #1 in_valid = 0;
    wait_done(0, 2);
    repeat (4) @(negedge clk);
    chk("t3_frame0", flog[0], 16'h92A5); chk("t3_frame1", flog[1], 16'h925A);
    chk("t3_gap", last_hi, 3); chk("t3_dones", dones, 2); chk("t3_accs", accs, 2);
    // inputs changed and in_valid pulsed mid-frame
    clear();
    send(0, 0, 7'h33, 8'h3C);
    repeat (20) @(negedge clk);
    read_write = 1; addr = 7'h7F; data = 8'h00; in_valid = 1;
    @(negedge clk) in_valid = 0;
    wait_done(0, 1);
    repeat (20) @(negedge clk);
    chk("t4_bits", rx, 16'h333C); chk("t4_dones", dones, 1); chk("t4_accs", accs, 1);
    chk("t4_idle", busy, 0); chk("t4_ncs", n_cs, 1);
    // reset after 7th sclk rise
    clear();
    send(0, 1, 7'h2B, 8'hAA);
    for (int i = 0; i < 3000 && rises < 7; i++) @(negedge clk);
    chk("t5_rises", rises, 7); chk("t5_pre_sclk", sclk, 1); chk("t5_pre_copi", copi, 1);
    #2 rst = 1;
    #1 chk("t5_ncs", n_cs, 1); chk("t5_sclk", sclk, 0); chk("t5_copi", copi, 0);
    chk("t5_busy", busy, 0); chk("t5_ready_in_rst", in_ready, 0);
    @(negedge clk) rst = 0;
    #1 chk("t5_ready", in_ready, 1);
    repeat (200) @(negedge clk);
    chk("t5_no_done", dones, 0); chk("t5_ncs_idle", n_cs, 1);
    // CLK_DIV=2, CS_GAP=1 instance
    clear();
    send(1, 0, 7'h01, 8'h55);
    wait_done(1, 1);
    repeat (4) @(negedge clk);
    chk("t6_bits", rx_b, 16'h0155); chk("t6_rises", rises_b, 16); chk("t6_period", period_b, 4);
    chk("t6_latency", done_cyc_b - acc_cyc_b, 67); chk("t6_cs_low", cs_low_b, 66);
    chk("t6_ready", in_ready_b, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
